// File: rtl/event_line_encoder_pkg.sv
// -----------------------------------------------------------------------------
// line_codec_pkg
// Shared constants, FSM state type and mask helper for the event line encoder.
//   N_LINES     : number of event lines (8)
//   CODE_W      : width of the encoded line index (3)
//   state_t     : offer state machine states (IDLE, OFFER)
//   onehot_mask : one-hot vector selecting the line named by an index
// -----------------------------------------------------------------------------
package line_codec_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = $clog2(N_LINES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // One-hot mask with only bit idx set; used to clear a single pending line.
  function automatic logic [N_LINES-1:0] onehot_mask(input logic [CODE_W-1:0] idx);
    logic [N_LINES-1:0] mask;
    mask = {{(N_LINES-1){1'b0}}, 1'b1} << idx;
    return mask;
  endfunction

endpackage

// File: rtl/event_line_encoder_if.sv
// -----------------------------------------------------------------------------
// event_line_encoder_if
// Valid/ready code channel from the encoder to its single consumer.
//   out_valid : code is valid (driven by master)
//   out_ready : consumer ready (driven by slave)
//   code      : encoded line index (driven by master)
// -----------------------------------------------------------------------------
interface event_line_encoder_if;
  import line_codec_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] code;

  modport master (output out_valid, output code, input out_ready);
  modport slave  (input out_valid, input code, output out_ready);

endinterface

// File: rtl/prio_enc_8to3.sv
// -----------------------------------------------------------------------------
// prio_enc_8to3
// Combinational priority encoder: index of the highest set bit (bit 7 wins).
//   vec : input vector
//   idx : index of the highest set bit (0 when vec is zero)
//   any : at least one bit of vec is set
// -----------------------------------------------------------------------------
module prio_enc_8to3
  import line_codec_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  output logic [CODE_W-1:0]  idx,
  output logic               any
);

  // Highest-priority lookup; an all-zero vector yields index 0.
  always_comb begin
    idx = 3'd0;
    any = |vec;
    casez (vec)
      8'b1???_????: idx = 3'd7;
      8'b01??_????: idx = 3'd6;
      8'b001?_????: idx = 3'd5;
      8'b0001_????: idx = 3'd4;
      8'b0000_1???: idx = 3'd3;
      8'b0000_01??: idx = 3'd2;
      8'b0000_001?: idx = 3'd1;
      default:      idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/event_line_encoder.sv
// -----------------------------------------------------------------------------
// event_line_encoder
// Captures single-cycle event pulses into a pending register and offers the
// index of the highest pending line over a valid/ready channel. An accepted
// code clears its pending bit; a new pulse on the same edge keeps it pending.
//   clk, rst_n : clock, asynchronous active-low reset
//   Enable     : capture enable for F
//   F          : event lines, bit 7 highest priority
//   ovf_clear  : synchronous clear of the sticky overflow flags
//   out_if     : code channel (out_valid, out_ready, code)
//   pending    : current pending register
//   overflow   : sticky per-line flag, event hit an already-pending line
// -----------------------------------------------------------------------------
module event_line_encoder
  import line_codec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Enable,
  input  logic [N_LINES-1:0]   F,
  input  logic                 ovf_clear,
  event_line_encoder_if.master out_if,
  output logic [N_LINES-1:0]   pending,
  output logic [N_LINES-1:0]   overflow
);

  state_t              state_r, state_nxt_s;
  logic [N_LINES-1:0]  pending_r, pending_nxt_s;
  logic [N_LINES-1:0]  overflow_r, overflow_nxt_s;
  logic [CODE_W-1:0]   code_r, code_nxt_s;
  logic                valid_r, valid_nxt_s;

  logic [CODE_W-1:0]   enc_idx_s;
  logic                enc_any_s;
  logic                accept_s;
  logic [N_LINES-1:0]  set_s;
  logic [N_LINES-1:0]  clr_mask_s;

  prio_enc_8to3 u_prio (
    .vec (pending_r),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  assign pending          = pending_r;
  assign overflow         = overflow_r;
  assign out_if.out_valid = valid_r;
  assign out_if.code      = code_r;

  // Pending/overflow update: a same-edge set beats the accept clear.
  always_comb begin
    accept_s       = valid_r & out_if.out_ready;
    set_s          = {N_LINES{1'b0}};
    clr_mask_s     = {N_LINES{1'b0}};
    overflow_nxt_s = overflow_r;
    if (Enable) begin
      set_s = F;
    end else begin
      set_s = {N_LINES{1'b0}};
    end
    if (accept_s) begin
      clr_mask_s = onehot_mask(code_r);
    end else begin
      clr_mask_s = {N_LINES{1'b0}};
    end
    pending_nxt_s = (pending_r & ~clr_mask_s) | set_s;
    // A line being accepted on this edge is not an overflow.
    if (ovf_clear) begin
      overflow_nxt_s = {N_LINES{1'b0}};
    end else begin
      overflow_nxt_s = overflow_r | (set_s & pending_r & ~clr_mask_s);
    end
  end

  // Offer FSM next-state: the code is latched on entry to OFFER and held there.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = valid_r;
    code_nxt_s  = code_r;
    case (state_r)
      IDLE: begin
        if (enc_any_s) begin
          state_nxt_s = OFFER;
          valid_nxt_s = 1'b1;
          code_nxt_s  = enc_idx_s;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      OFFER: begin
        if (out_if.out_ready) begin
          state_nxt_s = IDLE;
          valid_nxt_s = 1'b0;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= {N_LINES{1'b0}};
      overflow_r <= {N_LINES{1'b0}};
      code_r     <= {CODE_W{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
      code_r     <= code_nxt_s;
      valid_r    <= valid_nxt_s;
    end
  end

endmodule
